// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified memory port between the CPU I-side
// (read-only) and D-side (read/write) ports. Each side has a one-deep pending
// slot; one transaction is in flight at a time. The mem_* request outputs are
// registered, and responses are steered combinationally to the current owner.
// Optional build macro: ARB_ROUND_ROBIN_EN. When it is defined, a tie goes to
// the side that was not granted last. When it is undefined, D-side wins a tie.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic [MASK_W-1:0] imem_rmask,
  output logic [DATA_W-1:0] imem_rdata,
  output logic              imem_resp,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [MASK_W-1:0] dmem_rmask,
  input  logic [MASK_W-1:0] dmem_wmask,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_resp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MASK_W-1:0] mem_rmask,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              arb_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_I,
    S_ISSUE_D,
    S_WAIT_I,
    S_WAIT_D
  } state_t;

  state_t r_state, w_next;

  // Per-side pending slots
  logic              r_i_pend;
  logic [ADDR_W-1:0] r_i_addr;
  logic [MASK_W-1:0] r_i_rmask;
  logic              r_d_pend;
  logic [ADDR_W-1:0] r_d_addr;
  logic [MASK_W-1:0] r_d_rmask;
  logic [MASK_W-1:0] r_d_wmask;
  logic [DATA_W-1:0] r_d_wdata;

  // Registered unified-port drive
  logic [ADDR_W-1:0] r_mem_addr;
  logic [MASK_W-1:0] r_mem_rmask;
  logic [MASK_W-1:0] r_mem_wmask;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_err;

`ifdef ARB_ROUND_ROBIN_EN
  // 0 = I-side granted last, 1 = D-side granted last
  logic              r_last_grant;
`endif

  // Request qualification
  logic w_i_req, w_i_busy, w_i_new, w_i_err, w_i_av;
  logic w_d_rd, w_d_wr, w_d_req, w_d_busy, w_d_new, w_d_err, w_d_av;
  logic w_resp_err;

  // Decision / issue
  logic              w_decide, w_issue, w_pick_d;
  logic [ADDR_W-1:0] w_iss_addr;
  logic [MASK_W-1:0] w_iss_rmask;
  logic [MASK_W-1:0] w_iss_wmask;
  logic [DATA_W-1:0] w_iss_wdata;

  // Classify incoming requests. A side counts as busy while its slot is full
  // or its transaction is in ISSUE or WAIT. A busy side drops new requests.
  always_comb begin
    w_i_req    = |imem_rmask;
    w_i_busy   = r_i_pend || (r_state == S_ISSUE_I) || (r_state == S_WAIT_I);
    w_i_new    = w_i_req && !w_i_busy;
    w_i_err    = w_i_req && w_i_busy;
    w_i_av     = r_i_pend || w_i_new;

    w_d_rd     = |dmem_rmask;
    w_d_wr     = |dmem_wmask;
    w_d_req    = w_d_rd || w_d_wr;
    w_d_busy   = r_d_pend || (r_state == S_ISSUE_D) || (r_state == S_WAIT_D);
    w_d_new    = w_d_req && !w_d_busy && !(w_d_rd && w_d_wr);
    w_d_err    = w_d_req && (w_d_busy || (w_d_rd && w_d_wr));
    w_d_av     = r_d_pend || w_d_new;

    w_resp_err = mem_resp && ((r_state == S_IDLE) || (r_state == S_ISSUE_I) ||
                              (r_state == S_ISSUE_D));
  end

  // Next-state logic. A grant decision happens in IDLE, and also on the
  // response edge in WAIT, so a pending slot issues back to back.
  always_comb begin
    w_next   = r_state;
    w_decide = 1'b0;
    w_issue  = 1'b0;
    w_pick_d = 1'b0;
    case (r_state)
      S_IDLE:    w_decide = 1'b1;
      S_ISSUE_I: w_next = S_WAIT_I;
      S_ISSUE_D: w_next = S_WAIT_D;
      S_WAIT_I,
      S_WAIT_D: begin
        if (mem_resp) begin
          w_next   = S_IDLE;
          w_decide = 1'b1;
        end
      end
      default:   w_next = S_IDLE;
    endcase
    if (w_decide && (w_i_av || w_d_av)) begin
      w_issue = 1'b1;
      if (w_i_av && w_d_av) begin
`ifdef ARB_ROUND_ROBIN_EN
        w_pick_d = !r_last_grant;
`else
        w_pick_d = 1'b1;
`endif
      end else begin
        w_pick_d = w_d_av;
      end
      w_next = w_pick_d ? S_ISSUE_D : S_ISSUE_I;
    end
  end

  // Issue source: a full slot takes priority over a request arriving this edge
  always_comb begin
    w_iss_addr  = '0;
    w_iss_rmask = '0;
    w_iss_wmask = '0;
    w_iss_wdata = '0;
    if (w_pick_d) begin
      if (r_d_pend) begin
        w_iss_addr  = r_d_addr;
        w_iss_rmask = r_d_rmask;
        w_iss_wmask = r_d_wmask;
        w_iss_wdata = r_d_wdata;
      end else begin
        w_iss_addr  = dmem_addr;
        w_iss_rmask = dmem_rmask;
        w_iss_wmask = dmem_wmask;
        w_iss_wdata = dmem_wdata;
      end
    end else begin
      w_iss_addr  = r_i_pend ? r_i_addr  : imem_addr;
      w_iss_rmask = r_i_pend ? r_i_rmask : imem_rmask;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Unified port drive. Masks are high only in ISSUE. Address and data hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_addr  <= '0;
      r_mem_rmask <= '0;
      r_mem_wmask <= '0;
      r_mem_wdata <= '0;
    end else if (w_issue) begin
      r_mem_addr  <= w_iss_addr;
      r_mem_rmask <= w_iss_rmask;
      r_mem_wmask <= w_iss_wmask;
      r_mem_wdata <= w_iss_wdata;
    end else begin
      r_mem_rmask <= '0;
      r_mem_wmask <= '0;
    end
  end

  // I-side slot. It clears when granted and loads when a new request loses
  // or waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_pend  <= 1'b0;
      r_i_addr  <= '0;
      r_i_rmask <= '0;
    end else if (w_issue && !w_pick_d) begin
      r_i_pend  <= 1'b0;
    end else if (w_i_new) begin
      r_i_pend  <= 1'b1;
      r_i_addr  <= imem_addr;
      r_i_rmask <= imem_rmask;
    end
  end

  // D-side slot. It follows the same rules and also captures wmask and wdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_pend  <= 1'b0;
      r_d_addr  <= '0;
      r_d_rmask <= '0;
      r_d_wmask <= '0;
      r_d_wdata <= '0;
    end else if (w_issue && w_pick_d) begin
      r_d_pend  <= 1'b0;
    end else if (w_d_new) begin
      r_d_pend  <= 1'b1;
      r_d_addr  <= dmem_addr;
      r_d_rmask <= dmem_rmask;
      r_d_wmask <= dmem_wmask;
      r_d_wdata <= dmem_wdata;
    end
  end

  // Sticky protocol-error flag. Only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_err <= 1'b0;
    else if (w_i_err || w_d_err || w_resp_err) r_err <= 1'b1;
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember the most recent grant for tie-breaking
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_last_grant <= 1'b0;
    else if (w_issue) r_last_grant <= w_pick_d;
  end
`endif

  // Steer the response to the WAIT owner. The other side stays quiet.
  always_comb begin
    imem_resp  = (r_state == S_WAIT_I) && mem_resp;
    dmem_resp  = (r_state == S_WAIT_D) && mem_resp;
    imem_rdata = imem_resp ? mem_rdata : '0;
    dmem_rdata = dmem_resp ? mem_rdata : '0;
  end

  assign mem_addr  = r_mem_addr;
  assign mem_rmask = r_mem_rmask;
  assign mem_wmask = r_mem_wmask;
  assign mem_wdata = r_mem_wdata;
  assign arb_err   = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter in its default build (fixed D-side priority).
// It uses a per-cycle vector table, hand-written reset and error sequences, and
// a random traffic phase that is checked against a response queue.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask;
  logic        imem_resp, dmem_resp;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_rmask, mem_wmask;
  logic        mem_resp, arb_err;

  // Memory side: manual drive, or an automatic responder with latency 2
  logic        mem_auto, man_resp, auto_resp;
  logic [31:0] man_rdata, auto_rdata, lat_addr;
  logic [1:0]  cnt;

  int n_chk, n_err;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .arb_err(arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_resp  = mem_auto ? auto_resp  : man_resp;
  assign mem_rdata = mem_auto ? auto_rdata : man_rdata;

  function automatic logic [31:0] model(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Automatic memory: answers two cycles after the ISSUE cycle
  always @(negedge clk) begin
    if (!mem_auto) begin
      cnt        <= 2'd0;
      auto_resp  <= 1'b0;
      auto_rdata <= '0;
    end else begin
      auto_resp  <= (cnt == 2'd1);
      auto_rdata <= (cnt == 2'd1) ? model(lat_addr) : '0;
      if (|mem_rmask || |mem_wmask) begin
        cnt      <= 2'd2;
        lat_addr <= mem_addr;
      end else if (cnt != 2'd0) begin
        cnt <= cnt - 2'd1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr_in();
    imem_addr = '0; imem_rmask = '0;
    dmem_addr = '0; dmem_rmask = '0; dmem_wmask = '0; dmem_wdata = '0;
    man_resp = 1'b0; man_rdata = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_rmask"}, mem_rmask, 0);
    chk({tag, "_mem_wmask"}, mem_wmask, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_imem_resp"}, imem_resp, 0);
    chk({tag, "_dmem_resp"}, dmem_resp, 0);
    chk({tag, "_imem_rdata"}, imem_rdata, 0);
    chk({tag, "_dmem_rdata"}, dmem_rdata, 0);
    chk({tag, "_arb_err"}, arb_err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_in();
    rst = 1'b1;
    #1 chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  irm;  logic [31:0] ia;
    logic [3:0]  drm;  logic [3:0]  dwm;  logic [31:0] da;  logic [31:0] dwd;
    logic        mrs;  logic [31:0] mrd;
    logic [3:0]  emr;  logic [3:0]  emw;  logic [31:0] ema; logic [31:0] emwd;
    logic        eir;  logic [31:0] eird;
    logic        edr;  logic [31:0] edrd;
    logic        eerr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
      input logic [3:0] irm, input logic [31:0] ia,
      input logic [3:0] drm, input logic [3:0] dwm, input logic [31:0] da, input logic [31:0] dwd,
      input logic mrs, input logic [31:0] mrd,
      input logic [3:0] emr, input logic [3:0] emw, input logic [31:0] ema, input logic [31:0] emwd,
      input logic eir, input logic [31:0] eird, input logic edr, input logic [31:0] edrd,
      input logic eerr);
    vec_t r;
    r.irm = irm; r.ia = ia; r.drm = drm; r.dwm = dwm; r.da = da; r.dwd = dwd;
    r.mrs = mrs; r.mrd = mrd; r.emr = emr; r.emw = emw; r.ema = ema; r.emwd = emwd;
    r.eir = eir; r.eird = eird; r.edr = edr; r.edrd = edrd; r.eerr = eerr;
    return r;
  endfunction

  logic [31:0] qi[$], qd[$];
  logic [31:0] a;
  bit          ib, db;

  initial begin
    rst = 1'b1; mem_auto = 1'b0; n_chk = 0; n_err = 0;
    clr_in();

    //  irm  ia            drm  dwm  da     dwd      mrs mrd     emr  emw  ema           emwd    eir eird    edr edrd    err
    // I read, memory answers three cycles after issue
    tbl.push_back(v(4'hF, 32'h6000_0000, 0, 0, 0, 0,          0, 0,      0,   0,   0, 0,               0, 0,      0, 0,      0));
    tbl.push_back(v(0, 0,             0, 0, 0, 0,             0, 0,      4'hF, 0,  32'h6000_0000, 0,   0, 0,      0, 0,      0));
    tbl.push_back(v(0, 0,             0, 0, 0, 0,             0, 0,      0,   0,   0, 0,               0, 0,      0, 0,      0));
    tbl.push_back(v(0, 0,             0, 0, 0, 0,             0, 0,      0,   0,   0, 0,               0, 0,      0, 0,      0));
    tbl.push_back(v(0, 0,             0, 0, 0, 0,             1, 32'h13, 0,   0,   0, 0,               1, 32'h13, 0, 0,      0));
    // D write
    tbl.push_back(v(0, 0,             0, 4'h3, 32'h100, 32'hBEEF, 0, 0,  0,   0,   0, 0,               0, 0,      0, 0,      0));
    tbl.push_back(v(0, 0,             0, 0, 0, 0,             0, 0,      0,   4'h3, 32'h100, 32'hBEEF, 0, 0,      0, 0,      0));
    tbl.push_back(v(0, 0,             0, 0, 0, 0,             0, 0,      0,   0,   0, 0,               0, 0,      0, 0,      0));
    tbl.push_back(v(0, 0,             0, 0, 0, 0,             1, 32'h1234, 0, 0,   0, 0,               0, 0,      1, 32'h1234, 0));
    // Tie: D wins, and I issues the cycle after D's response
    tbl.push_back(v(4'hF, 32'h200,    4'hF, 0, 32'h300, 0,    0, 0,      0,   0,   0, 0,               0, 0,      0, 0,      0));
    tbl.push_back(v(0, 0,             0, 0, 0, 0,             0, 0,      4'hF, 0,  32'h300, 0,         0, 0,      0, 0,      0));
    tbl.push_back(v(0, 0,             0, 0, 0, 0,             0, 0,      0,   0,   0, 0,               0, 0,      0, 0,      0));
    tbl.push_back(v(0, 0,             0, 0, 0, 0,             1, 32'hAAAA, 0, 0,   0, 0,               0, 0,      1, 32'hAAAA, 0));
    tbl.push_back(v(0, 0,             0, 0, 0, 0,             0, 0,      4'hF, 0,  32'h200, 0,         0, 0,      0, 0,      0));
    tbl.push_back(v(0, 0,             0, 0, 0, 0,             0, 0,      0,   0,   0, 0,               0, 0,      0, 0,      0));
    tbl.push_back(v(0, 0,             0, 0, 0, 0,             1, 32'hBBBB, 0, 0,   0, 0,               1, 32'hBBBB, 0, 0,    0));
    // Second I request while I is in WAIT: error, dropped, first response still delivered
    tbl.push_back(v(4'hF, 32'h400,    0, 0, 0, 0,             0, 0,      0,   0,   0, 0,               0, 0,      0, 0,      0));
    tbl.push_back(v(0, 0,             0, 0, 0, 0,             0, 0,      4'hF, 0,  32'h400, 0,         0, 0,      0, 0,      0));
    tbl.push_back(v(4'hF, 32'h500,    0, 0, 0, 0,             0, 0,      0,   0,   0, 0,               0, 0,      0, 0,      0));
    tbl.push_back(v(0, 0,             0, 0, 0, 0,             0, 0,      0,   0,   0, 0,               0, 0,      0, 0,      1));
    tbl.push_back(v(0, 0,             0, 0, 0, 0,             1, 32'hCCCC, 0, 0,   0, 0,               1, 32'hCCCC, 0, 0,    1));
    tbl.push_back(v(0, 0,             0, 0, 0, 0,             0, 0,      0,   0,   0, 0,               0, 0,      0, 0,      1));
    tbl.push_back(v(0, 0,             0, 0, 0, 0,             0, 0,      0,   0,   0, 0,               0, 0,      0, 0,      1));
    // Read and write masks together, then an unsolicited response
    tbl.push_back(v(0, 0,             4'hF, 4'hF, 32'h600, 0, 0, 0,      0,   0,   0, 0,               0, 0,      0, 0,      1));
    tbl.push_back(v(0, 0,             0, 0, 0, 0,             0, 0,      0,   0,   0, 0,               0, 0,      0, 0,      1));
    tbl.push_back(v(0, 0,             0, 0, 0, 0,             1, 32'hDDDD, 0, 0,   0, 0,               0, 0,      0, 0,      1));

    do_reset();

    foreach (tbl[k]) begin
      @(negedge clk);
      imem_rmask = tbl[k].irm; imem_addr = tbl[k].ia;
      dmem_rmask = tbl[k].drm; dmem_wmask = tbl[k].dwm;
      dmem_addr = tbl[k].da; dmem_wdata = tbl[k].dwd;
      man_resp = tbl[k].mrs; man_rdata = tbl[k].mrd;
      #1;
      chk($sformatf("v%0d_mem_rmask", k), mem_rmask, tbl[k].emr);
      chk($sformatf("v%0d_mem_wmask", k), mem_wmask, tbl[k].emw);
      if (tbl[k].emr != 0 || tbl[k].emw != 0)
        chk($sformatf("v%0d_mem_addr", k), mem_addr, tbl[k].ema);
      if (tbl[k].emw != 0)
        chk($sformatf("v%0d_mem_wdata", k), mem_wdata, tbl[k].emwd);
      chk($sformatf("v%0d_imem_resp", k), imem_resp, tbl[k].eir);
      chk($sformatf("v%0d_imem_rdata", k), imem_rdata, tbl[k].eird);
      chk($sformatf("v%0d_dmem_resp", k), dmem_resp, tbl[k].edr);
      chk($sformatf("v%0d_dmem_rdata", k), dmem_rdata, tbl[k].edrd);
      chk($sformatf("v%0d_arb_err", k), arb_err, tbl[k].eerr);
    end

    // Read and write masks together from a clean state
    do_reset();
    @(negedge clk); dmem_rmask = 4'hF; dmem_wmask = 4'hF; dmem_addr = 32'h40;
    @(negedge clk); clr_in(); #1;
    chk("both_err", arb_err, 1);
    chk("both_rmask", mem_rmask, 0);
    chk("both_wmask", mem_wmask, 0);

    // Unsolicited response in IDLE from a clean state
    do_reset();
    @(negedge clk); man_resp = 1'b1; man_rdata = 32'h5555; #1;
    chk("idle_resp_i", imem_resp, 0);
    chk("idle_resp_d", dmem_resp, 0);
    chk("idle_rdata_d", dmem_rdata, 0);
    @(negedge clk); man_resp = 1'b0; #1;
    chk("idle_resp_err", arb_err, 1);

    // Response during ISSUE is not forwarded and is flagged
    do_reset();
    @(negedge clk); imem_rmask = 4'hF; imem_addr = 32'h80;
    @(negedge clk); imem_rmask = '0; man_resp = 1'b1; man_rdata = 32'h66; #1;
    chk("issue_mem_rmask", mem_rmask, 4'hF);
    chk("issue_resp_i", imem_resp, 0);
    @(negedge clk); man_resp = 1'b0; #1;
    chk("issue_resp_err", arb_err, 1);

    // Asynchronous reset while a registered mask is high
    do_reset();
    @(negedge clk); dmem_rmask = 4'hF; dmem_addr = 32'h90;
    @(negedge clk); dmem_rmask = '0; #1;
    chk("ar_pre_rmask", mem_rmask, 4'hF);
    #1 rst = 1'b1;
    #1 chk("ar_rmask", mem_rmask, 0);
    chk("ar_addr", mem_addr, 0);
    @(negedge clk); rst = 1'b0;

    // Reset in WAIT_D, a stray late response, then a normal I read
    do_reset();
    @(negedge clk); dmem_rmask = 4'hF; dmem_addr = 32'h700;
    @(negedge clk); dmem_rmask = '0; #1;
    chk("w6_issue_addr", mem_addr, 32'h700);
    @(negedge clk); man_resp = 1'b1; man_rdata = 32'h77; #1;
    chk("w6_pre_resp", dmem_resp, 1);
    #1 rst = 1'b1;
    #1 chk("w6_rst_resp", dmem_resp, 0);
    chk("w6_rst_rdata", dmem_rdata, 0);
    chk("w6_rst_addr", mem_addr, 0);
    man_resp = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); man_resp = 1'b1; man_rdata = 32'h99; #1;
    chk("w6_stray_i", imem_resp, 0);
    chk("w6_stray_d", dmem_resp, 0);
    @(negedge clk); man_resp = 1'b0; #1;
    chk("w6_stray_err", arb_err, 1);
    imem_rmask = 4'hF; imem_addr = 32'h800;
    @(negedge clk); imem_rmask = '0; #1;
    chk("w6_i_rmask", mem_rmask, 4'hF);
    chk("w6_i_addr", mem_addr, 32'h800);
    @(negedge clk);
    @(negedge clk); man_resp = 1'b1; man_rdata = 32'h1234_5678; #1;
    chk("w6_i_resp", imem_resp, 1);
    chk("w6_i_rdata", imem_rdata, 32'h1234_5678);
    @(negedge clk); man_resp = 1'b0; #1;
    chk("w6_i_resp_end", imem_resp, 0);

    // Random traffic with a scoreboard of expected read data per side
    do_reset();
    @(negedge clk); mem_auto = 1'b1;
    ib = 0; db = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      imem_rmask = '0; dmem_rmask = '0; dmem_wmask = '0;
      if (c < 400) begin
        if (!ib && $urandom_range(0, 2) == 0) begin
          a = $urandom & 32'h0000_FFFC;
          imem_addr = a; imem_rmask = 4'hF;
          qi.push_back(model(a)); ib = 1;
        end
        if (!db && $urandom_range(0, 2) == 0) begin
          a = $urandom & 32'h0000_FFFC;
          dmem_addr = a;
          if ($urandom_range(0, 1) == 1) dmem_rmask = 4'hF;
          else begin
            dmem_wmask = 4'($urandom_range(1, 15));
            dmem_wdata = $urandom;
          end
          qd.push_back(model(a)); db = 1;
        end
      end
      #1;
      if (imem_resp) begin
        if (qi.size() == 0) chk("tr_i_spurious", imem_resp, 0);
        else begin chk("tr_i_rdata", imem_rdata, qi.pop_front()); ib = 0; end
      end
      if (dmem_resp) begin
        if (qd.size() == 0) chk("tr_d_spurious", dmem_resp, 0);
        else begin chk("tr_d_rdata", dmem_rdata, qd.pop_front()); db = 0; end
      end
      if (c >= 400 && qi.size() == 0 && qd.size() == 0) break;
    end
    chk("tr_i_drained", qi.size(), 0);
    chk("tr_d_drained", qd.size(), 0);
    chk("tr_err", arb_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
